// File: rtl/spi_main_mc_if.sv
// spi_main_mc_if: request/data inputs and DAC pin outputs of the multi-lane SPI main
interface spi_main_mc_if #(
    parameter int WORD_WIDTH = 16,
    parameter int NUM_CH     = 2,
    parameter int PS_WIDTH   = 2
);
    localparam int PSW = PS_WIDTH > 0 ? PS_WIDTH : 1;
    logic                         load;
    logic [NUM_CH*WORD_WIDTH-1:0] parallel_in;
    logic [PSW-1:0]               power_state;
    logic                         sclk;
    logic [NUM_CH-1:0]            mosi;
    logic                         csb;
    logic                         busy;
    logic                         done;
    modport master (input load, parallel_in, power_state, output sclk, mosi, csb, busy, done);
    modport slave  (output load, parallel_in, power_state, input sclk, mosi, csb, busy, done);
endinterface

// File: rtl/spi_main_mc.sv
// spi_main_mc: transmit-only SPI main driving NUM_CH DAC lanes from one SCLK/CSB
module spi_main_mc #(
    parameter int WORD_WIDTH = 16,
    parameter int NUM_CH     = 2,
    parameter int PS_WIDTH   = 2,
    parameter int CLK_DIV    = 1,
    parameter int CS_GAP     = 2,
    parameter bit CPOL       = 1'b0,
    parameter bit LSB_FIRST  = 1'b0
) (
    input  logic          sys_clk,
    input  logic          rst_n,
    spi_main_mc_if.master bus
);
    localparam int FRAME_W = PS_WIDTH + WORD_WIDTH;
    localparam int BW = FRAME_W > 1 ? $clog2(FRAME_W) : 1;
    localparam int HW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int GW = CS_GAP > 0 ? $clog2(CS_GAP + 1) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t            r_state, w_next;
    logic [FRAME_W-1:0] r_sr [NUM_CH];
    logic [FRAME_W-1:0] w_frame [NUM_CH];
    logic [BW-1:0]     r_bit;
    logic [HW-1:0]     r_half;
    logic [GW-1:0]     r_gap;
    logic [NUM_CH-1:0] r_mosi;
    logic              r_sclk, r_csb, r_busy, r_done;
    logic              w_csb, w_busy, w_done;
    logic              w_wrap, w_lead, w_last, w_end, w_gap_end;

    // Shift register always emits its MSB, so LSB-first frames are reversed at capture
    function automatic logic [FRAME_W-1:0] orient(input logic [FRAME_W-1:0] f);
        orient = f;
        for (int j = 0; j < FRAME_W; j++) orient[j] = LSB_FIRST ? f[FRAME_W-1-j] : f[j];
    endfunction

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        if (PS_WIDTH > 0) begin : g_ps
            assign w_frame[k] = orient({bus.power_state[PS_WIDTH-1:0], bus.parallel_in[k*WORD_WIDTH +: WORD_WIDTH]});
        end else begin : g_nops
            assign w_frame[k] = orient(bus.parallel_in[k*WORD_WIDTH +: WORD_WIDTH]);
        end
    end

    assign w_wrap    = r_half == HW'(CLK_DIV - 1);
    assign w_lead    = r_sclk == CPOL;
    assign w_last    = r_bit == BW'(FRAME_W - 1);
    assign w_end     = w_wrap && !w_lead && w_last;
    assign w_gap_end = r_gap == GW'(CS_GAP - 1);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_csb   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_csb   <= w_csb;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    always_comb begin
        w_next = (r_state == IDLE)  ? (bus.load ? SHIFT : IDLE) :
                 (r_state == SHIFT) ? (w_end ? (CS_GAP == 0 ? IDLE : GAP) : SHIFT) :
                                      (w_gap_end ? IDLE : GAP);
    end

    always_comb begin
        w_csb  = w_next != SHIFT;
        w_busy = w_next != IDLE;
        w_done = (r_state == SHIFT) && w_end;
    end

    // Next bit is launched on the trailing edge; the final trailing edge parks mosi low
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_half <= '0;
            r_bit  <= '0;
            r_gap  <= '0;
            r_sclk <= CPOL;
            r_mosi <= '0;
            for (int k = 0; k < NUM_CH; k++) r_sr[k] <= '0;
        end else if (r_state == IDLE) begin
            r_half <= '0;
            r_bit  <= '0;
            r_gap  <= '0;
            r_sclk <= CPOL;
            for (int k = 0; k < NUM_CH; k++) begin
                r_sr[k]   <= w_frame[k] << 1;
                r_mosi[k] <= bus.load & w_frame[k][FRAME_W-1];
            end
        end else if (r_state == SHIFT) begin
            r_half <= w_wrap ? '0 : r_half + 1'b1;
            if (w_wrap) r_sclk <= ~r_sclk;
            if (w_wrap && !w_lead) begin
                r_bit <= r_bit + 1'b1;
                for (int k = 0; k < NUM_CH; k++) begin
                    r_mosi[k] <= !w_last & r_sr[k][FRAME_W-1];
                    r_sr[k]   <= r_sr[k] << 1;
                end
            end
        end else begin
            r_gap <= r_gap + 1'b1;
        end
    end

    assign bus.sclk = r_sclk;
    assign bus.mosi = r_mosi;
    assign bus.csb  = r_csb;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: tb/tb_spi_main_mc.sv
// tb_spi_main_mc: three parameterisations checked every cycle against a frame-timing model
module tb_spi_main_mc;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        ld [3];
    logic [15:0] lane [3][4];
    logic [1:0]  ps [3];
    logic [3:0]  mo [3];
    logic        sc [3], cs [3], bz [3], dn [3];

    spi_main_mc_if #(.WORD_WIDTH(16), .NUM_CH(2), .PS_WIDTH(2)) if_a ();
    spi_main_mc_if #(.WORD_WIDTH(16), .NUM_CH(2), .PS_WIDTH(2)) if_b ();
    spi_main_mc_if #(.WORD_WIDTH(8),  .NUM_CH(4), .PS_WIDTH(0)) if_c ();

    spi_main_mc u_a (.sys_clk(clk), .rst_n(rst_n), .bus(if_a.master));
    spi_main_mc #(.CLK_DIV(3), .CS_GAP(0), .CPOL(1'b1)) u_b (.sys_clk(clk), .rst_n(rst_n), .bus(if_b.master));
    spi_main_mc #(.WORD_WIDTH(8), .NUM_CH(4), .PS_WIDTH(0), .CS_GAP(1), .LSB_FIRST(1'b1))
        u_c (.sys_clk(clk), .rst_n(rst_n), .bus(if_c.master));

    assign if_a.load = ld[0];
    assign if_a.parallel_in = {lane[0][1], lane[0][0]};
    assign if_a.power_state = ps[0];
    assign if_b.load = ld[1];
    assign if_b.parallel_in = {lane[1][1], lane[1][0]};
    assign if_b.power_state = ps[1];
    assign if_c.load = ld[2];
    assign if_c.parallel_in = {lane[2][3][7:0], lane[2][2][7:0], lane[2][1][7:0], lane[2][0][7:0]};
    assign if_c.power_state = 1'b0;

    assign mo[0] = {2'b00, if_a.mosi};
    assign mo[1] = {2'b00, if_b.mosi};
    assign mo[2] = if_c.mosi;
    assign sc[0] = if_a.sclk;
    assign sc[1] = if_b.sclk;
    assign sc[2] = if_c.sclk;
    assign cs[0] = if_a.csb;
    assign cs[1] = if_b.csb;
    assign cs[2] = if_c.csb;
    assign bz[0] = if_a.busy;
    assign bz[1] = if_b.busy;
    assign bz[2] = if_c.busy;
    assign dn[0] = if_a.done;
    assign dn[1] = if_b.done;
    assign dn[2] = if_c.done;

    function automatic int pd(input int i);   return i == 1 ? 3 : 1; endfunction
    function automatic int pg(input int i);   return i == 0 ? 2 : (i == 1 ? 0 : 1); endfunction
    function automatic bit pcp(input int i);  return i == 1; endfunction
    function automatic bit plsb(input int i); return i == 2; endfunction
    function automatic int pn(input int i);   return i == 2 ? 4 : 2; endfunction
    function automatic int pf(input int i);   return i == 2 ? 8 : 18; endfunction
    function automatic int tl(input int i);   return 2 * pd(i) * pf(i); endfunction

    function automatic logic [17:0] frame_of(input int i, input logic [15:0] w, input logic [1:0] p);
        return i == 2 ? {10'b0, w[7:0]} : {p, w};
    endfunction

    int n_run = 0, n_fail = 0, cyc = 0;

    task automatic chk(input string nm, input int i, input logic [63:0] got, input logic [63:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s inst%0d t=%0t got %0h want %0h", nm, i, $time, got, want);
        end
    endtask

    // Model: mk = cycles since the capture edge (-1 when idle); outputs follow from the timing rules
    int          mk [3] = '{-1, -1, -1};
    logic [17:0] mfr [3][4];
    logic        e_cs, e_sc, e_bz, e_dn;
    logic [3:0]  e_mo;
    int          bi, bp;

    logic [63:0] rec [3][4], last_rec [3][4];
    int          ne [3], last_ne [3], lowc [3], last_low [3], highc [3], last_high [3];
    int          fall_cyc [3], last_period [3], dcnt [3];
    logic        pcs [3], psc [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) mk[i] = -1;
            else if (mk[i] < 0 || mk[i] >= tl(i) + pg(i)) begin
                mk[i] = ld[i] ? 0 : -1;
                if (ld[i]) for (int l = 0; l < 4; l++) mfr[i][l] = frame_of(i, lane[i][l], ps[i]);
            end else mk[i]++;
        end
        #1;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            e_mo = 4'b0;
            if (mk[i] < 0) begin
                e_cs = 1'b1; e_sc = pcp(i); e_bz = 1'b0; e_dn = 1'b0;
            end else if (mk[i] < tl(i)) begin
                e_cs = 1'b0; e_bz = 1'b1; e_dn = 1'b0;
                e_sc = pcp(i) ^ ((mk[i] / pd(i)) % 2 == 1);
                bi = mk[i] / (2 * pd(i));
                bp = plsb(i) ? bi : pf(i) - 1 - bi;
                for (int l = 0; l < pn(i); l++) e_mo[l] = mfr[i][l][bp];
            end else begin
                e_cs = 1'b1; e_sc = pcp(i);
                e_bz = mk[i] < tl(i) + pg(i);
                e_dn = mk[i] == tl(i);
            end
            chk("csb", i, 64'(cs[i]), 64'(e_cs));
            chk("sclk", i, 64'(sc[i]), 64'(e_sc));
            chk("mosi", i, 64'(mo[i]), 64'(e_mo));
            chk("busy", i, 64'(bz[i]), 64'(e_bz));
            chk("done", i, 64'(dn[i]), 64'(e_dn));
            if (!cs[i] && psc[i] == pcp(i) && sc[i] != pcp(i)) begin
                for (int l = 0; l < 4; l++) rec[i][l] = {rec[i][l][62:0], mo[i][l]};
                ne[i]++;
            end
            if (!pcs[i] && cs[i]) begin
                last_low[i] = lowc[i];
                last_ne[i] = ne[i];
                ne[i] = 0;
                highc[i] = 0;
                for (int l = 0; l < 4; l++) begin
                    last_rec[i][l] = rec[i][l];
                    rec[i][l] = '0;
                end
            end
            if (pcs[i] && !cs[i]) begin
                last_high[i] = highc[i];
                last_period[i] = cyc - fall_cyc[i];
                fall_cyc[i] = cyc;
                lowc[i] = 0;
            end
            if (cs[i]) highc[i]++; else lowc[i]++;
            dcnt[i] += int'(dn[i]);
            pcs[i] = cs[i];
            psc[i] = sc[i];
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int i);
        ld[i] = 1'b1;
        tick(1);
        ld[i] = 1'b0;
    endtask

    int d0;

    initial begin
        for (int i = 0; i < 3; i++) begin
            ld[i] = 1'b0; ps[i] = 2'b0;
            ne[i] = 0; lowc[i] = 0; highc[i] = 0; dcnt[i] = 0; fall_cyc[i] = 0;
            last_ne[i] = 0; last_low[i] = 0; last_high[i] = 0; last_period[i] = 0;
            pcs[i] = 1'b1; psc[i] = pcp(i);
            for (int l = 0; l < 4; l++) begin
                lane[i][l] = '0; rec[i][l] = '0; last_rec[i][l] = '0; mfr[i][l] = '0;
            end
        end
        #1 rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        chk("rst_csb", 0, 64'(cs[0]), 64'd1);
        chk("rst_sclk", 1, 64'(sc[1]), 64'd1);
        chk("rst_busy", 0, 64'(bz[0]), 64'd0);

        lane[0][0] = 16'ha5a5; lane[0][1] = 16'h1234; ps[0] = 2'b11;
        pulse(0);
        tick(45);
        chk("frame_l0", 0, last_rec[0][0], 64'(18'b11_1010010110100101));
        chk("frame_l1", 0, last_rec[0][1], 64'(18'b11_0001001000110100));
        chk("edges", 0, 64'(last_ne[0]), 64'd18);
        chk("csb_low", 0, 64'(last_low[0]), 64'd36);
        chk("done_cnt", 0, 64'(dcnt[0]), 64'd1);

        ld[0] = 1'b1;
        tick(1);
        lane[0][0] = 16'h04d8; ps[0] = 2'b01;
        tick(37);
        chk("b2b_frame1", 0, last_rec[0][0], 64'(18'b11_1010010110100101));
        tick(2);
        ld[0] = 1'b0;
        tick(45);
        chk("b2b_frame2", 0, last_rec[0][0], 64'(18'b01_0000010011011000));
        chk("b2b_gap", 0, 64'(last_high[0]), 64'd3);
        chk("b2b_period", 0, 64'(last_period[0]), 64'd39);

        lane[1][0] = 16'ha5a5; lane[1][1] = 16'h1234; ps[1] = 2'b11;
        pulse(1);
        tick(115);
        chk("div3_low", 1, 64'(last_low[1]), 64'd108);
        chk("div3_edges", 1, 64'(last_ne[1]), 64'd18);
        chk("div3_l0", 1, last_rec[1][0], 64'(18'b11_1010010110100101));

        lane[2][0] = 16'h01; lane[2][1] = 16'h80; lane[2][2] = 16'hff; lane[2][3] = 16'h00;
        pulse(2);
        tick(20);
        chk("lsb_l0", 2, last_rec[2][0], 64'h80);
        chk("lsb_l1", 2, last_rec[2][1], 64'h01);
        chk("lsb_l2", 2, last_rec[2][2], 64'hff);
        chk("lsb_l3", 2, last_rec[2][3], 64'h00);
        chk("lsb_edges", 2, 64'(last_ne[2]), 64'd8);
        chk("lsb_low", 2, 64'(last_low[2]), 64'd16);

        lane[0][0] = 16'ha5a5; lane[0][1] = 16'h1234; ps[0] = 2'b11;
        pulse(0);
        tick(15);
        rst_n = 1'b0;
        #1;
        chk("arst_csb", 0, 64'(cs[0]), 64'd1);
        chk("arst_sclk", 0, 64'(sc[0]), 64'd0);
        chk("arst_mosi", 0, 64'(mo[0]), 64'd0);
        chk("arst_busy", 0, 64'(bz[0]), 64'd0);
        chk("arst_done", 0, 64'(dn[0]), 64'd0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        pulse(0);
        tick(45);
        chk("post_rst_l0", 0, last_rec[0][0], 64'(18'b11_1010010110100101));
        chk("post_rst_edges", 0, 64'(last_ne[0]), 64'd18);

        d0 = dcnt[0];
        pulse(0);
        tick(9);
        pulse(0);
        tick(26);
        pulse(0);
        tick(45);
        chk("ignored_loads", 0, 64'(dcnt[0] - d0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
